// File: rtl/sar_capture_array.sv
// Shared-DAC SAR sequencer for an ADC array.
// It converts one channel or scans all of them, and stores each result in that channel's slice.
module sar_capture_array #(
  parameter int NUM_ADC = 8,
  parameter int RES     = 10,
  parameter int SETTLE  = 2,
  parameter int CH_W    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   scan_en,
  input  logic [CH_W-1:0]        ch_sel,
  input  logic                   abort,
  input  logic                   comp,
  input  logic [NUM_ADC-1:0]     ack,
  output logic [RES-1:0]         dac_code,
  output logic [RES-1:0]         bitctrl,
  output logic [CH_W-1:0]        ch_active,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_ADC-1:0]     valid,
  output logic [NUM_ADC-1:0]     overrun,
  output logic [NUM_ADC*RES-1:0] out
);

  localparam int KW = $clog2(RES);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [RES-1:0] MSB = {1'b1, {(RES-1){1'b0}}};
  localparam logic [CH_W-1:0] LAST = CH_W'(NUM_ADC - 1);
  localparam logic [CH_W:0] NCH = (CH_W+1)'(NUM_ADC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_WRITE
  } state_t;

  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [RES-1:0] work_q, work_d;
  logic scan_q, scan_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [RES-1:0] dac_q, dac_d;
  logic [RES-1:0] bit_q, bit_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic [NUM_ADC-1:0] valid_q, valid_d;
  logic [NUM_ADC-1:0] ovr_q, ovr_d;
  logic [NUM_ADC*RES-1:0] out_q, out_d;
  logic [RES-1:0] nxt;
  logic load;
  logic ch_ok;

  assign ch_ok = ({1'b0, ch_sel} < NCH);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    scan_d  = scan_q;
    ch_d    = ch_q;
    dac_d   = dac_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    valid_d = valid_q & ~ack;
    ovr_d   = ovr_q & ~ack;
    out_d   = out_q;
    nxt     = work_q;
    load    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && (scan_en || ch_ok)) begin
          scan_d = scan_en;
          ch_d   = scan_en ? '0 : ch_sel;
          load   = 1'b1;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SW'(SETTLE - 1))
          state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        nxt[k_q] = comp;
        if (k_q != '0) begin
          nxt[k_q - 1'b1] = 1'b1;
          k_d     = k_q - 1'b1;
          bit_d   = RES'(1) << (k_q - 1'b1);
          dac_d   = nxt;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else begin
          dac_d   = '0;
          bit_d   = '0;
          done_d  = 1'b1;
          state_d = S_WRITE;
        end
        work_d = nxt;
      end
      S_WRITE: begin
        for (int i = 0; i < NUM_ADC; i++) begin
          if (ch_q == CH_W'(i)) begin
            out_d[i*RES +: RES] = work_q;
            valid_d[i] = 1'b1;
            // overrun looks at valid before any same-cycle ack
            if (valid_q[i])
              ovr_d[i] = 1'b1;
          end
        end
        if (scan_q && ch_q != LAST) begin
          ch_d = ch_q + 1'b1;
          load = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase

    if (load) begin
      k_d     = KW'(RES - 1);
      cnt_d   = '0;
      work_d  = MSB;
      dac_d   = MSB;
      bit_d   = MSB;
      state_d = S_SETTLE;
    end

    // abort never blocks the write of a WRITE cycle already underway
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      dac_d   = '0;
      bit_d   = '0;
      done_d  = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      work_q  <= '0;
      scan_q  <= 1'b0;
      ch_q    <= '0;
      dac_q   <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= '0;
      ovr_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      scan_q  <= scan_d;
      ch_q    <= ch_d;
      dac_q   <= dac_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      out_q   <= out_d;
    end
  end

  assign dac_code  = dac_q;
  assign bitctrl   = bit_q;
  assign ch_active = ch_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign valid     = valid_q;
  assign overrun   = ovr_q;
  assign out       = out_q;

endmodule

// File: doc/sar_capture_array.md
Name: sar_capture_array

Overview:
Parametrised SAR conversion sequencer and result store for an array of NUM_ADC single-comparator SAR ADCs sharing one trial-DAC bus. It drives the trial code and a one-hot bit strobe, samples the comparator after a programmable settle time, and assembles each RES-bit result MSB-first. It writes each result into that channel's slice of a flat output bus, with per-channel valid and overrun flags. It supports single-channel conversions and a scan mode that converts every channel in turn.

Parameters:
NUM_ADC, 8, number of ADC channels (>=2)
RES, 10, bits per conversion (>=2)
SETTLE, 2, DAC settle cycles per bit before the comparator sample (>=1)
CH_W, 3, width of channel index; must satisfy 2**CH_W >= NUM_ADC

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  conversion request pulse; sampled only in IDLE
scan_en  in  1  sampled with start: 1 = convert ch 0..NUM_ADC-1, 0 = convert ch_sel only
ch_sel  in  CH_W  channel index for single conversion
abort  in  1  cancel conversion in progress
comp  in  1  comparator of active channel; 1 = Vin >= dac_code
ack  in  NUM_ADC  per-channel clear of valid/overrun
dac_code  out  RES  trial code to shared DAC
bitctrl  out  RES  one-hot strobe of bit under trial
ch_active  out  CH_W  channel currently converting
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse in WRITE state
valid  out  NUM_ADC  sticky per-channel result-ready
overrun  out  NUM_ADC  sticky: result written while valid still set
out  out  NUM_ADC*RES  results; ch i at [i*RES +: RES]

Behaviour:
- Reset (rst=1 at edge) forces: state IDLE, dac_code=0, bitctrl=0, ch_active=0, busy=0, done=0, valid=0, overrun=0, out=0. This applies mid-conversion too; partial results are discarded.
- States: IDLE, SETTLE, SAMPLE, WRITE. All outputs are registered.
- IDLE, start=1:
  - Rejected (stay IDLE, no output change) if scan_en=0 and ch_sel>=NUM_ADC.
  - Otherwise latch the channel (ch_sel, or 0 if scan_en), latch scan_en, then go to SETTLE with bit k=RES-1, dac_code=1<<k, bitctrl=1<<k, settle counter=0.
- SETTLE: counter increments each cycle. After SETTLE cycles in this state, go to SAMPLE.
- SAMPLE (one cycle): at the closing edge, bit k of the working code is set to comp.
  - If k>0: k decrements; dac_code = working code with new bit k set; bitctrl = 1<<k; go to SETTLE.
  - If k=0: go to WRITE.
- WRITE (one cycle):
  - Out slice of ch_active takes the final code; valid[ch] is set; done=1.
  - If valid[ch] was already 1, overrun[ch] is set.
  - dac_code=0, bitctrl=0.
  - Next state: if scan and ch_active<NUM_ADC-1, ch_active+1 and SETTLE (MSB trial); else IDLE.
- Latency: with start sampled at edge of cycle 0, done is high in cycle RES*(SETTLE+1)+1. Each further scan channel adds RES*(SETTLE+1)+1 cycles.
- busy: 0 only in IDLE. start while busy is ignored.
- abort=1 in any non-IDLE state: next state is IDLE with dac_code=0, bitctrl=0, and no write. abort wins over WRITE transitions, but a WRITE already in progress in the current cycle completes. abort in IDLE has no effect.
- ack[i]=1 clears valid[i] and overrun[i]. If a WRITE to channel i and ack[i] occur in the same cycle, the set wins, and overrun is evaluated against the pre-ack valid.
- out slices hold their value until rewritten or reset.

Test Plan:
- Default params, single conversion, ch_sel=3, comp model Vin=677 (comp = 677>=dac_code) -> trial sequence 512,768,640,704,672,688,680,676,678,677; done at cycle 31; out[39:30]=677; valid=8'h08; busy low at cycle 32.
- comp held 1 then held 0 on ch 0 -> out[9:0]=1023, then second run 0; after first run no ack -> overrun[0]=1 after second run; ack[0] pulse -> valid[0]=0, overrun[0]=0.
- scan_en=1, channel i Vin=100*i+5 -> slices 5,105,...,705; valid=8'hFF; done pulses at cycles 31,62,...,248; busy falls at cycle 249.
- abort asserted at cycle 10 of a conversion on ch 2 -> busy=0 and dac_code=0 at cycle 11; out and valid unchanged; a new start is then accepted normally.
- rst=1 at cycle 15 mid-scan -> all outputs zero next cycle; start with ch_sel=7 (valid) accepted; ch_sel=7 at NUM_ADC=6 rejected, busy stays 0.
- ack[5] and WRITE to ch 5 in the same cycle -> valid[5]=1 afterwards; start during busy is ignored (ch_active unchanged).
